// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter in front of a shared bitwise logic unit.
// Grants one requester per cycle and holds its tagged result in a one-entry output register.
module logic_unit_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned WIDTH   = 8,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [3*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ID_W-1:0]  r_ptr;
  logic [WIDTH-1:0] r_data;
  logic [ID_W-1:0]  r_id;
  logic             r_err;

  logic             w_slot_free;
  logic             w_gnt_found;
  logic [ID_W-1:0]  w_gnt_idx;
  logic             w_accept;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_res;
  logic             w_err;

  assign w_slot_free = (r_state == ST_EMPTY) || rsp_ready;
  assign w_accept    = w_slot_free && w_gnt_found;

  // First valid requester at or after the pointer, wrapping around
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_gnt_found && req_valid[ID_W'(r_ptr + ID_W'(k))]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = ID_W'(r_ptr + ID_W'(k));
      end
    end
  end

  // Select the granted requester's payload and drive its ready
  always_comb begin
    w_op      = '0;
    w_a       = '0;
    w_b       = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_op         = req_op[3*i +: 3];
        w_a          = req_a[WIDTH*i +: WIDTH];
        w_b          = req_b[WIDTH*i +: WIDTH];
        req_ready[i] = w_accept;
      end
    end
  end

  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    case (w_op)
      OP_AND:  w_res = w_a & w_b;
      OP_OR:   w_res = w_a | w_b;
      OP_NOT:  w_res = ~w_a;
      OP_NAND: w_res = ~(w_a & w_b);
      OP_NOR:  w_res = ~(w_a | w_b);
      OP_XOR:  w_res = w_a ^ w_b;
      OP_XNOR: w_res = ~(w_a ^ w_b);
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (rsp_ready && !w_accept) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Result register and pointer only move on an accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_data <= '0;
      r_id   <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_ptr  <= w_gnt_idx + ID_W'(1);
      r_data <= w_res;
      r_id   <= w_gnt_idx;
      r_err  <= w_err;
    end
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign busy      = rsp_valid;
  assign rsp_data  = r_data;
  assign rsp_id    = r_id;
  assign rsp_err   = r_err;

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared bitwise logic unit that performs AND, OR, NOT, NAND, NOR, XOR and XNOR on WIDTH-bit operands.
- NUM_REQ independent requesters each submit an opcode and operands over a valid/ready handshake.
- The block grants one request per cycle, computes the result, and holds it in a one-entry output register with backpressure. Each result is tagged with the ID of the requester that issued it.
- Sits between the requesting engines and any consumer of logic results.

Parameters:
- NUM_REQ, 4, number of requesters; power of 2, range 2..8.
- WIDTH, 8, operand and result width in bits.
- ID_W, derived localparam = log2(NUM_REQ), width of the requester ID.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_op  in  3*NUM_REQ  opcode of requester i in bits [3i+2:3i].
- req_a  in  WIDTH*NUM_REQ  operand a of requester i in bits [WIDTH*i+WIDTH-1:WIDTH*i].
- req_b  in  WIDTH*NUM_REQ  operand b, packed the same way as req_a.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  WIDTH  result.
- rsp_id  out  ID_W  index of the requester that issued the result.
- rsp_err  out  1  result came from an illegal opcode.
- busy  out  1  equals rsp_valid.

Behaviour:
- Reset (async on rst_n low, takes effect without a clock edge):
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0.
  - Round-robin pointer ptr=0; FSM enters EMPTY.
- Opcodes (bitwise on all WIDTH bits):
  - 0 AND, 1 OR, 2 NOT a (b ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR.
  - 7 is illegal: result 0, rsp_err=1.
- FSM states:
  - EMPTY: no result held. Moves to FULL on an accept.
  - FULL: result held. Stays FULL if rsp_ready and a new accept occur in the same cycle. Moves to EMPTY if rsp_ready is high with no new accept. Holds with no change if rsp_ready is low.
- Accept condition: slot_free = (state==EMPTY) || rsp_ready.
- Grant (combinational):
  - Search req_valid starting at index ptr, upward with wrap modulo NUM_REQ; the first set bit is granted.
  - req_ready[g] = slot_free && req_valid[g]; all other bits are 0.
  - req_ready never asserts for a requester with req_valid low.
- Accept edge (req_valid[g] && req_ready[g]):
  - rsp_data, rsp_id=g and rsp_err are registered.
  - rsp_valid=1 from the next cycle; latency is 1 cycle.
  - ptr <= (g+1) mod NUM_REQ.
- Pointer hold: ptr is unchanged on cycles with no accept.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,2,3,0,...; no requester waits more than NUM_REQ-1 grants.
- Backpressure:
  - While FULL and rsp_ready=0, rsp_data, rsp_id and rsp_err are stable, and req_ready is all 0.
  - Requesters must hold their valid, op and operands until accepted.
- Simultaneous drain and accept: the old result is consumed and the new result is loaded on the same edge. rsp_valid stays 1, giving full throughput of one result per cycle.
- Reset mid-operation: a held result is discarded, and no response is produced for it after reset release.
- Illegal opcode: it is accepted and arbitrated exactly like a legal one, and it advances ptr.

Test Plan:
- Reset, then req_valid[2]=1, op=0, a=8'hF0, b=8'h3C, rsp_ready=1 -> req_ready=4'b0100 in the same cycle; next cycle rsp_valid=1, rsp_data=8'h30, rsp_id=2, rsp_err=0; ptr=3.
- Opcode sweep from requester 0 with a=8'hA5, b=8'h0F, ops 0..7 -> rsp_data 05, AF, 5A, FA, 50, AA, 55, 00 in order; rsp_err=1 only for op 7.
- All four requesters held valid, rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3; rsp_valid continuously 1 from the second cycle.
- Result held, rsp_ready=0 for 5 cycles with requesters 1 and 3 valid -> req_ready=0, rsp outputs stable. Then rsp_ready=1 -> requester 1 (or 3, per ptr) is accepted in that same cycle, and rsp_data is replaced on the next edge with no bubble.
- Starting from ptr=3, requesters 0 and 3 valid -> requester 3 is granted first, then 0 (wrap-around); ptr ends at 1.
- Assert rst_n=0 asynchronously between edges while FULL -> rsp_valid drops to 0 immediately; after release, ptr=0, and with requester 1 valid the next grant is to requester 1.
